chu_io_pwm2_core: RTL

- Multi-channel PWM core on the standard MMIO slot interface. Successor to the single-mode PWM core.
- Adds:
  - double-buffered (shadow/active) duty registers committed at the period boundary, for glitch-free updates;
  - edge- or center-aligned counting mode;
  - global enable and per-channel enable mask;
  - register readback and a period counter.
- Drives W external PWM pins.

---
 rtl/chu_io_pwm2_core.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/chu_io_pwm2_core.sv
// chu_io_pwm2_core -- multi-channel PWM core on an MMIO slot.
//
// Each of W channels compares a shared duty counter d against its active duty
// register. Duties are double buffered: software writes a shadow copy and the
// active copy is loaded at the period boundary, so an update never produces a
// runt pulse. The counter runs edge-aligned (sawtooth) or center-aligned
// (triangle), stepped by a programmable prescaler.
//
// Register map (word address):
//   0      dvsr       prescaler divisor, tick every dvsr+1 clocks
//   1      ctrl       bit0 en, bit1 center mode; any write restarts the counter
//   2      mask       per-channel enable
//   3      period_cnt read-only count of completed periods
//   4      pol        output polarity (only with PWM_POLARITY_INV_EN)
//   0x10+i shadow duty of channel i (R+1 bits, so 100% is reachable)
//
// Optional feature macro: PWM_POLARITY_INV_EN adds the pol register and XORs
// it into the registered outputs.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   cs/read/write  slot select and strobes (reads have no side effects)
//   addr, wr_data  word address and write data
//   rd_data        combinational read data selected by addr
//   pwm_out        registered PWM outputs
module chu_io_pwm2_core #(
    parameter int W = 8,
    parameter int R = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    output logic [W-1:0] pwm_out
);
    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
    localparam logic [R-1:0] D_MAX = '1;

    logic [31:0]  dvsr_q, dvsr_d, q_q, q_d, period_q, period_d;
    logic [1:0]   ctrl_q, ctrl_d;
    logic [W-1:0] mask_q, mask_d, pwm_q, pwm_next;
    logic [R:0]   shadow_q [W];
    logic [R:0]   shadow_d [W];
    logic [R:0]   active_q [W];
    logic [R:0]   active_d [W];
    logic [R-1:0] d_q, d_d;
    dir_t         dir_q, dir_d;
    logic         wr_en, en, center, tick, boundary;
    logic [W-1:0] pol_q;

    // Reads are pure; the strobe carries no information for this core.
    logic unused_read;
    assign unused_read = read;

    assign wr_en  = cs && write;
    assign en     = ctrl_q[0];
    assign center = ctrl_q[1];
    assign tick   = en && (q_q == 32'd0);

    always_comb begin
        dvsr_d   = dvsr_q;
        ctrl_d   = ctrl_q;
        mask_d   = mask_q;
        period_d = period_q;
        shadow_d = shadow_q;
        active_d = active_q;
        q_d      = q_q;
        d_d      = d_q;
        dir_d    = dir_q;
        boundary = 1'b0;

        if (wr_en && addr == 5'd0) dvsr_d = wr_data;
        if (wr_en && addr == 5'd1) ctrl_d = wr_data[1:0];
        if (wr_en && addr == 5'd2) mask_d = wr_data[W-1:0];
        for (int i = 0; i < W; i++)
            if (wr_en && addr[4] && addr[3:0] == 4'(i)) shadow_d[i] = wr_data[R:0];

        if (!en) begin
            q_d   = '0;
            d_d   = '0;
            dir_d = UP;
        end else begin
            q_d = (q_q == dvsr_q) ? 32'd0 : q_q + 32'd1;
            if (tick) begin
                if (!center) begin
                    d_d      = d_q + R'(1);
                    boundary = (d_q == D_MAX);
                end else if (dir_q == UP) begin
                    // Top of the triangle: turn around without repeating D_MAX.
                    if (d_q == D_MAX) begin
                        d_d   = d_q - R'(1);
                        dir_d = DOWN;
                    end else begin
                        d_d = d_q + R'(1);
                    end
                end else begin
                    // Stepping 1 -> 0 ends the period; 0 is counted once, going up.
                    d_d = d_q - R'(1);
                    if (d_q == R'(1)) begin
                        dir_d    = UP;
                        boundary = 1'b1;
                    end
                end
            end
        end

        // A ctrl write restarts the counter cleanly in either mode.
        if (wr_en && addr == 5'd1) begin
            q_d   = '0;
            d_d   = '0;
            dir_d = UP;
        end

        if (boundary) period_d = period_q + 32'd1;

        // Commit uses shadow_d so a write landing on the boundary is not lost.
        if (!en || boundary) active_d = shadow_d;

        for (int i = 0; i < W; i++)
            pwm_next[i] = en && mask_q[i] && ({1'b0, d_q} < active_q[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvsr_q   <= '0;
            ctrl_q   <= '0;
            mask_q   <= '0;
            period_q <= '0;
            q_q      <= '0;
            d_q      <= '0;
            dir_q    <= UP;
            pwm_q    <= '0;
            for (int i = 0; i < W; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            dvsr_q   <= dvsr_d;
            ctrl_q   <= ctrl_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            q_q      <= q_d;
            d_q      <= d_d;
            dir_q    <= dir_d;
            pwm_q    <= pwm_next ^ pol_q;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

`ifdef PWM_POLARITY_INV_EN
    always_ff @(posedge clk) begin
        if (reset)
            pol_q <= '0;
        else if (wr_en && addr == 5'd4)
            pol_q <= wr_data[W-1:0];
    end
`else
    assign pol_q = '0;
`endif

    always_comb begin
        rd_data = '0;
        if (addr[4]) begin
            for (int i = 0; i < W; i++)
                if (addr[3:0] == 4'(i)) rd_data = 32'(shadow_q[i]);
        end else begin
            case (addr[3:0])
                4'd0:    rd_data = dvsr_q;
                4'd1:    rd_data = {30'd0, ctrl_q};
                4'd2:    rd_data = 32'(mask_q);
                4'd3:    rd_data = period_q;
`ifdef PWM_POLARITY_INV_EN
                4'd4:    rd_data = 32'(pol_q);
`endif
                default: rd_data = '0;
            endcase
        end
    end

    assign pwm_out = pwm_q;

endmodule
